// File: rtl/nibble_frame_tx_pkg.sv
// Shared definitions for the nibble-slot frame interface (transmitter and receiver).
// Both ends use slot_index so they agree on which counter values carry which nibble.
package nibble_frame_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_e;

    localparam int DEF_NIBBLES     = 3;
    localparam int DEF_FRAME_LEN   = 16;
    localparam int DEF_FIRST_SLOT  = 4;
    localparam int DEF_SLOT_STRIDE = 2;

    localparam int SLOT_NONE = -1;

    // Maps a frame counter value to the nibble index driven in that cycle, or SLOT_NONE.
    function automatic int slot_index(input int cnt,
                                      input int first_slot,
                                      input int slot_stride,
                                      input int nibbles);
        int idx;
        idx = SLOT_NONE;
        if ((cnt >= first_slot) && (cnt < first_slot + slot_stride * nibbles)) begin
            idx = (cnt - first_slot) / slot_stride;
        end
        return idx;
    endfunction

endpackage

// File: rtl/nibble_frame_tx_hold.sv
// One-entry holding register between the input handshake and the frame engine.
// Push and pop never coincide: ready is low whenever there is something to pop.
module nibble_hold_buf #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         push;

    assign push = push_valid_i && !full_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push) begin
            full_d = 1'b1;
            data_d = push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign push_ready_o = !full_q;
    assign full_o       = full_q;
    assign data_o       = data_q;

endmodule

// File: rtl/nibble_frame_tx.sv
// Nibble-slot frame transmitter: one word per fixed-length frame, one nibble per slot,
// with a one-entry hold buffer so consecutive frames run without an idle cycle.
module nibble_frame_tx
    import nibble_frame_tx_pkg::*;
#(
    parameter int NIBBLES     = DEF_NIBBLES,
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int FIRST_SLOT  = DEF_FIRST_SLOT,
    parameter int SLOT_STRIDE = DEF_SLOT_STRIDE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [4*NIBBLES-1:0] in_data_i,
    output logic                 enable_o,
    output logic [3:0]           data_out_o,
    output logic                 frame_start_o,
    output logic                 busy_o
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     active_q, active_d;
    logic             enable_q;
    logic [3:0]       data_out_q, data_out_d;
    logic             frame_start_q;

    logic             accept;
    logic             hold_ready;
    logic             hold_full;
    logic [W-1:0]     hold_data;
    logic             hold_push;
    logic             hold_pop;
    int               slot;

    assign accept = in_valid_i && hold_ready;

    nibble_hold_buf #(
        .W (W)
    ) u_hold (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (hold_push),
        .push_ready_o (hold_ready),
        .push_data_i  (in_data_i),
        .pop_i        (hold_pop),
        .full_o       (hold_full),
        .data_o       (hold_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        hold_push = 1'b0;
        hold_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = FRAME;
                    cnt_d    = '0;
                    active_d = in_data_i;
                end
            end
            FRAME: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    hold_push = accept;
                end else begin
                    // Hold full implies in_ready low, so the direct-accept branch
                    // can only be taken with an empty hold.
                    cnt_d = '0;
                    if (hold_full) begin
                        hold_pop = 1'b1;
                        active_d = hold_data;
                    end else if (accept) begin
                        active_d = in_data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they line up with cnt_q after the edge.
    always_comb begin
        data_out_d = '0;
        slot       = slot_index(int'(cnt_d), FIRST_SLOT, SLOT_STRIDE, NIBBLES);
        if (state_d == FRAME) begin
            for (int k = 0; k < NIBBLES; k++) begin
                if (slot == k) begin
                    data_out_d = active_d[k*4 +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            active_q      <= '0;
            enable_q      <= 1'b0;
            data_out_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            enable_q      <= (state_d == FRAME);
            data_out_q    <= data_out_d;
            frame_start_q <= (state_d == FRAME) && (cnt_d == '0);
        end
    end

    assign in_ready_o    = hold_ready;
    assign enable_o      = enable_q;
    assign data_out_o    = data_out_q;
    assign frame_start_o = frame_start_q;
    assign busy_o        = (state_q == FRAME) || hold_full;

endmodule
